// File: rtl/snn_ctrl_pkg.sv
// Shared state encoding, default widths and per-neuron cycle count for the SNN layer sequencer.
package snn_ctrl_pkg;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_SEL_W  = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_CLEAR,
        ST_ACCUM,
        ST_DRAIN,
        ST_FIRE,
        ST_WRITE,
        ST_DONE
    } seq_state_t;

    // CLEAR + N_IN accumulate cycles + RD_LAT drain cycles + FIRE + WRITE
    function automatic int neuron_cycles(input int n_in, input int rd_lat);
        return n_in + rd_lat + 3;
    endfunction

endpackage

// File: rtl/ctrl_valid_delay.sv
// DEPTH-deep valid shift register that re-times issue flags to memory read data.
// Latency: DEPTH cycles; hold freezes all stages, flush clears them (flush wins).
module ctrl_valid_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    input  logic flush,
    input  logic in_vld,
    output logic out_vld
);

    logic [DEPTH-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (flush) begin
            sr_d = '0;
        end else if (!hold) begin
            sr_d = DEPTH'({sr_q, in_vld});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign out_vld = sr_q[DEPTH-1];

endmodule

// File: rtl/snn_layer_sequencer.sv
// Sequencer for one fully-connected SNN layer: per timestep and neuron, clear/accumulate/drain/fire/write.
// Latency: N_IN+RD_LAT+3 cycles per neuron; stall freezes everything and masks strobes, abort returns to IDLE.
module snn_layer_sequencer
    import snn_ctrl_pkg::*;
#(
    parameter int N_IN        = 16,
    parameter int N_OUT       = 8,
    parameter int N_TIMESTEPS = 4,
    parameter int RD_LAT      = 1,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int SEL_W       = DEF_SEL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic [SEL_W-1:0]  cntrl_u_in_select,
    output logic [SEL_W-1:0]  cntrl_u_out_select,
    output logic              cntrl_ac_reset,
    output logic              cntrl_ac_oen,
    output logic              cntrl_neu_reset,
    output logic              cntrl_proc_reset,
    output logic [ADDR_W-1:0] cntrl_in_spk_read_addr,
    output logic [ADDR_W-1:0] cntrl_spkblty_read_addr,
    output logic [ADDR_W-1:0] cntrl_potential_read_addr,
    output logic [ADDR_W-1:0] cntrl_beta_read_addr,
    output logic [ADDR_W-1:0] cntrl_potential_write_addr,
    output logic              cntrl_potential_write_we,
    output logic [ADDR_W-1:0] cntrl_spk_write_addr,
    output logic              cntrl_spk_write_we
);

    if ((N_TIMESTEPS * N_IN > (1 << ADDR_W)) || (N_OUT * N_IN > (1 << ADDR_W)) ||
        (N_TIMESTEPS * N_OUT > (1 << ADDR_W)) || (N_IN > (1 << SEL_W)) ||
        (N_OUT > (1 << SEL_W)) || (RD_LAT < 1)) begin : g_bad_params
        $error("snn_layer_sequencer: parameters do not fit ADDR_W/SEL_W or RD_LAT < 1");
    end

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] t_q, t_d;
    logic [SEL_W-1:0]  o_q, o_d;
    logic [SEL_W-1:0]  i_q, i_d;
    logic [15:0]       drain_q, drain_d;
    logic              acc_vld;
    logic              gate;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        o_d     = o_q;
        i_d     = i_q;
        drain_d = drain_q;
        if (abort) begin
            state_d = ST_IDLE;
            t_d     = '0;
            o_d     = '0;
            i_d     = '0;
            drain_d = '0;
        end else if (!stall) begin
            case (state_q)
                ST_IDLE:  if (start) state_d = ST_INIT;
                ST_INIT: begin
                    t_d     = '0;
                    o_d     = '0;
                    state_d = ST_CLEAR;
                end
                ST_CLEAR: begin
                    i_d     = '0;
                    state_d = ST_ACCUM;
                end
                ST_ACCUM: begin
                    if (i_q == SEL_W'(N_IN - 1)) begin
                        drain_d = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == 16'(RD_LAT - 1)) state_d = ST_FIRE;
                    else                            drain_d = drain_q + 1'b1;
                end
                ST_FIRE:  state_d = ST_WRITE;
                ST_WRITE: begin
                    if (o_q != SEL_W'(N_OUT - 1)) begin
                        o_d     = o_q + 1'b1;
                        state_d = ST_CLEAR;
                    end else if (t_q != ADDR_W'(N_TIMESTEPS - 1)) begin
                        o_d     = '0;
                        t_d     = t_q + 1'b1;
                        state_d = ST_CLEAR;
                    end else begin
                        // counters return to zero so DONE/IDLE present clean addresses
                        t_d     = '0;
                        o_d     = '0;
                        i_d     = '0;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            o_q     <= '0;
            i_q     <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            o_q     <= o_d;
            i_q     <= i_d;
            drain_q <= drain_d;
        end
    end

    ctrl_valid_delay #(
        .DEPTH (RD_LAT)
    ) u_valid_delay (
        .clk     (clk),
        .rst_n   (reset),
        .hold    (stall),
        .flush   (abort),
        .in_vld  (state_q == ST_ACCUM),
        .out_vld (acc_vld)
    );

    // Strobes are masked while frozen or aborting; addresses and selects keep their values.
    assign gate = stall | abort;
    assign busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done = (state_q == ST_DONE) && !gate;

    assign cntrl_neu_reset          = (state_q == ST_INIT) && !gate;
    assign cntrl_proc_reset         = (state_q == ST_INIT) && !gate;
    assign cntrl_ac_reset           = (state_q == ST_CLEAR) && !gate;
    assign cntrl_ac_oen             = acc_vld && !gate;
    assign cntrl_potential_write_we = (state_q == ST_WRITE) && !gate;
    assign cntrl_spk_write_we       = (state_q == ST_WRITE) && !gate;

    assign cntrl_u_in_select  = i_q;
    assign cntrl_u_out_select = busy ? o_q : '0;

    assign cntrl_in_spk_read_addr     = ADDR_W'(32'(t_q) * 32'(N_IN) + 32'(i_q));
    assign cntrl_spkblty_read_addr    = ADDR_W'(32'(o_q) * 32'(N_IN) + 32'(i_q));
    assign cntrl_potential_read_addr  = ADDR_W'(o_q);
    assign cntrl_beta_read_addr       = ADDR_W'(o_q);
    assign cntrl_potential_write_addr = ADDR_W'(o_q);
    assign cntrl_spk_write_addr       = ADDR_W'(32'(t_q) * 32'(N_OUT) + 32'(o_q));

endmodule

// File: tb/tb_snn_layer_sequencer.sv
// Bench for snn_layer_sequencer: default config plus a small RD_LAT=3 config, checked cycle by cycle
// against a schedule computed arithmetically from the cycle index within a run.
module tb_snn_layer_sequencer;

    typedef struct packed {
        logic [7:0] ctl;   // {busy, done, ac_reset, ac_oen, neu_reset, proc_reset, pot_we, spk_we}
        logic [5:0] isel;
        logic [5:0] osel;
        logic [8:0] in_a;
        logic [8:0] w_a;
        logic [8:0] pr_a;
        logic [8:0] b_a;
        logic [8:0] pw_a;
        logic [8:0] sw_a;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start_i [2];
    logic abort_i [2];
    logic stall_i [2];

    logic       busy_w [2], done_w [2], acr_w [2], oen_w [2], nr_w [2], pr_w [2], pwe_w [2], swe_w [2];
    logic [5:0] isel_w [2], osel_w [2];
    logic [8:0] ina_w [2], wa_w [2], pra_w [2], ba_w [2], pwa_w [2], swa_w [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    snn_layer_sequencer dut (
        .clk(clk), .reset(rst_n), .start(start_i[0]), .abort(abort_i[0]), .stall(stall_i[0]),
        .busy(busy_w[0]), .done(done_w[0]),
        .cntrl_u_in_select(isel_w[0]), .cntrl_u_out_select(osel_w[0]),
        .cntrl_ac_reset(acr_w[0]), .cntrl_ac_oen(oen_w[0]),
        .cntrl_neu_reset(nr_w[0]), .cntrl_proc_reset(pr_w[0]),
        .cntrl_in_spk_read_addr(ina_w[0]), .cntrl_spkblty_read_addr(wa_w[0]),
        .cntrl_potential_read_addr(pra_w[0]), .cntrl_beta_read_addr(ba_w[0]),
        .cntrl_potential_write_addr(pwa_w[0]), .cntrl_potential_write_we(pwe_w[0]),
        .cntrl_spk_write_addr(swa_w[0]), .cntrl_spk_write_we(swe_w[0])
    );

    snn_layer_sequencer #(
        .N_IN(4), .N_OUT(2), .N_TIMESTEPS(1), .RD_LAT(3)
    ) dut2 (
        .clk(clk), .reset(rst_n), .start(start_i[1]), .abort(abort_i[1]), .stall(stall_i[1]),
        .busy(busy_w[1]), .done(done_w[1]),
        .cntrl_u_in_select(isel_w[1]), .cntrl_u_out_select(osel_w[1]),
        .cntrl_ac_reset(acr_w[1]), .cntrl_ac_oen(oen_w[1]),
        .cntrl_neu_reset(nr_w[1]), .cntrl_proc_reset(pr_w[1]),
        .cntrl_in_spk_read_addr(ina_w[1]), .cntrl_spkblty_read_addr(wa_w[1]),
        .cntrl_potential_read_addr(pra_w[1]), .cntrl_beta_read_addr(ba_w[1]),
        .cntrl_potential_write_addr(pwa_w[1]), .cntrl_potential_write_we(pwe_w[1]),
        .cntrl_spk_write_addr(swa_w[1]), .cntrl_spk_write_we(swe_w[1])
    );

    function automatic int c_nin(input int c);  return (c == 0) ? 16 : 4; endfunction
    function automatic int c_nout(input int c); return (c == 0) ? 8 : 2;  endfunction
    function automatic int c_nt(input int c);   return (c == 0) ? 4 : 1;  endfunction
    function automatic int c_rdl(input int c);  return (c == 0) ? 1 : 3;  endfunction
    function automatic int c_last(input int c);
        return 1 + c_nt(c) * c_nout(c) * (c_nin(c) + c_rdl(c) + 3);
    endfunction

    function automatic obs_t get_obs(input int c);
        obs_t ob;
        ob.ctl  = {busy_w[c], done_w[c], acr_w[c], oen_w[c], nr_w[c], pr_w[c], pwe_w[c], swe_w[c]};
        ob.isel = isel_w[c];
        ob.osel = osel_w[c];
        ob.in_a = ina_w[c];
        ob.w_a  = wa_w[c];
        ob.pr_a = pra_w[c];
        ob.b_a  = ba_w[c];
        ob.pw_a = pwa_w[c];
        ob.sw_a = swa_w[c];
        return ob;
    endfunction

    // Expected outputs at run cycle e (INIT = 0, DONE = last, beyond = IDLE); gate = stall or abort.
    task automatic model(input int c, input int e, input bit gate, output obs_t ex,
                         output bit m_acc, output bit m_rd, output bit m_wr);
        int n_in, n_out, rdl, p, last, k, r, t, o, i;
        bit busy, dn, acr, oen, nr, pr, we;
        n_in = c_nin(c); n_out = c_nout(c); rdl = c_rdl(c);
        p = n_in + rdl + 3; last = c_last(c);
        ex = '0; m_acc = 0; m_rd = 0; m_wr = 0;
        busy = 0; dn = 0; acr = 0; oen = 0; nr = 0; pr = 0; we = 0;
        if (e == 0) begin
            busy = 1; nr = 1; pr = 1;
        end else if (e == last) begin
            dn = 1;
        end else if (e > last) begin
            m_acc = 1; m_rd = 1; m_wr = 1;
        end else begin
            k = (e - 1) / p; r = (e - 1) % p; t = k / n_out; o = k % n_out;
            busy = 1; m_rd = 1;
            ex.osel = 6'(o); ex.pr_a = 9'(o); ex.b_a = 9'(o);
            acr = (r == 0);
            if (r >= 1 && r <= n_in) begin
                i = r - 1; m_acc = 1;
                ex.isel = 6'(i); ex.in_a = 9'(t * n_in + i); ex.w_a = 9'(o * n_in + i);
            end
            oen = (r > rdl) && (r <= n_in + rdl);
            if (r == p - 1) begin
                we = 1; m_wr = 1; ex.pw_a = 9'(o); ex.sw_a = 9'(t * n_out + o);
            end
        end
        if (gate) begin
            dn = 0; acr = 0; oen = 0; nr = 0; pr = 0; we = 0;
        end
        ex.ctl = {busy, dn, acr, oen, nr, pr, we, we};
    endtask

    task automatic check(input int c, input int e, input bit gate, input string tag);
        obs_t ob, ex;
        bit m_acc, m_rd, m_wr;
        ob = get_obs(c);
        model(c, e, gate, ex, m_acc, m_rd, m_wr);
        checks++;
        assert (ob.ctl === ex.ctl) else begin
            errors++;
            $error("FAIL %s ctl e=%0d got=%b exp=%b", tag, e, ob.ctl, ex.ctl);
        end
        checks++;
        assert (ob.osel === ex.osel) else begin
            errors++;
            $error("FAIL %s out_select e=%0d got=%0d exp=%0d", tag, e, ob.osel, ex.osel);
        end
        if (m_acc) begin
            checks++;
            assert ({ob.isel, ob.in_a, ob.w_a} === {ex.isel, ex.in_a, ex.w_a}) else begin
                errors++;
                $error("FAIL %s in_sel/in_addr/w_addr e=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", tag, e,
                       ob.isel, ob.in_a, ob.w_a, ex.isel, ex.in_a, ex.w_a);
            end
        end
        if (m_rd) begin
            checks++;
            assert ({ob.pr_a, ob.b_a} === {ex.pr_a, ex.b_a}) else begin
                errors++;
                $error("FAIL %s pot/beta rd addr e=%0d got=%0d/%0d exp=%0d/%0d", tag, e,
                       ob.pr_a, ob.b_a, ex.pr_a, ex.b_a);
            end
        end
        if (m_wr) begin
            checks++;
            assert ({ob.pw_a, ob.sw_a} === {ex.pw_a, ex.sw_a}) else begin
                errors++;
                $error("FAIL %s pot/spk wr addr e=%0d got=%0d/%0d exp=%0d/%0d", tag, e,
                       ob.pw_a, ob.sw_a, ex.pw_a, ex.sw_a);
            end
        end
    endtask

    task automatic idle_checks(input int c, input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check(c, c_last(c) + 1, 1'b0, tag);
        end
    endtask

    // One run from a start pulse; pct = random stall/start percentage, optional directed stall,
    // abort at run cycle abort_e, or asynchronous reset at run cycle rst_e.
    task automatic run(input int c, input int pct, input int stall_at, input int stall_len,
                       input int abort_e, input int rst_e, input string tag);
        int last, e, wall, nstall, sdone, ndone, done_wall, npw, nsw, exp_sw;
        bit stl, abt;
        obs_t ob;
        last = c_last(c);
        e = 0; wall = 0; nstall = 0; sdone = 0; ndone = 0; done_wall = -1;
        npw = 0; nsw = 0; exp_sw = 0;
        @(posedge clk); #1 start_i[c] = 1'b1;
        @(posedge clk); #1 start_i[c] = 1'b0;
        while (e <= last) begin
            stl = (pct > 0 && $urandom_range(0, 99) < pct);
            if (e == stall_at && sdone < stall_len) begin
                stl = 1'b1;
                sdone++;
            end
            abt = (e == abort_e);
            stall_i[c] = stl;
            abort_i[c] = abt;
            start_i[c] = (pct > 0 && e < last) ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (e == rst_e) begin
                rst_n = 1'b0;
                #1 check(c, last + 1, 1'b0, {tag, "_async"});
                @(negedge clk);
                rst_n = 1'b1;
                stall_i[c] = 1'b0; start_i[c] = 1'b0;
                @(posedge clk); #1;
                break;
            end
            @(negedge clk);
            check(c, e, stl | abt, tag);
            ob = get_obs(c);
            if (ob.ctl[6]) begin
                ndone++;
                done_wall = wall;
            end
            if (ob.ctl[1]) npw++;
            if (ob.ctl[0]) begin
                checks++;
                assert (ob.sw_a === 9'(exp_sw)) else begin
                    errors++;
                    $error("FAIL %s spk_order got=%0d exp=%0d", tag, ob.sw_a, exp_sw);
                end
                exp_sw++;
                nsw++;
            end
            if (stl) nstall++;
            @(posedge clk); #1;
            if (abt) break;
            if (!stl) e++;
            wall++;
            checks++;
            assert (wall < 5000) else begin
                errors++;
                $error("FAIL %s timeout wall=%0d limit=5000", tag, wall);
                break;
            end
        end
        stall_i[c] = 1'b0; abort_i[c] = 1'b0; start_i[c] = 1'b0;
        idle_checks(c, 3, {tag, "_idle"});
        if (abort_e >= 0) begin
            checks++;
            assert (ndone == 0 && npw == 0 && nsw == 0) else begin
                errors++;
                $error("FAIL %s abort got done=%0d pw=%0d sw=%0d exp 0/0/0", tag, ndone, npw, nsw);
            end
        end else if (rst_e < 0) begin
            checks++;
            assert (ndone == 1) else begin
                errors++; $error("FAIL %s done_count got=%0d exp=1", tag, ndone);
            end
            checks++;
            assert (done_wall == last + nstall) else begin
                errors++; $error("FAIL %s done_cycle got=%0d exp=%0d", tag, done_wall, last + nstall);
            end
            checks++;
            assert (npw == c_nt(c) * c_nout(c) && nsw == c_nt(c) * c_nout(c)) else begin
                errors++;
                $error("FAIL %s write_counts got=%0d/%0d exp=%0d", tag, npw, nsw, c_nt(c) * c_nout(c));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start_i[k] = 1'b0; abort_i[k] = 1'b0; stall_i[k] = 1'b0;
        end
        @(negedge clk);
        check(0, c_last(0) + 1, 1'b0, "reset0");
        check(1, c_last(1) + 1, 1'b0, "reset1");
        @(negedge clk);
        rst_n = 1'b1;
        idle_checks(0, 2, "post_reset");

        run(0, 0, -1, 0, -1, -1, "base");
        run(1, 0, -1, 0, -1, -1, "small_rdlat3");
        run(0, 0, 9, 5, -1, -1, "stall_i7");
        run(0, 0, -1, 0, 19, -1, "abort_fire");
        run(0, 0, -1, 0, -1, -1, "rerun");

        @(posedge clk); #1 start_i[0] = 1'b1; abort_i[0] = 1'b1;
        @(posedge clk); #1 start_i[0] = 1'b0; abort_i[0] = 1'b0;
        idle_checks(0, 3, "start_abort_idle");

        run(0, 0, -1, 0, -1, 20, "reset_write");
        run(0, 20, -1, 0, -1, -1, "rand");
        run(1, 30, -1, 0, -1, -1, "rand_small");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snn_layer_sequencer.md
Name: snn_layer_sequencer

Overview:
- Parametrised sequencer for one fully-connected SNN layer over N_TIMESTEPS time steps.
- For every timestep and every output neuron it:
  - clears the accumulator;
  - streams N_IN input-spike and weight reads, with delayed accumulate-enables matched to memory read latency;
  - performs the neuron update, then writes back potential and output spike.
- Drives the neuron selector, accumulator, spike-processor and memory-controller strobes. Start/busy/done handshake; stall and abort support.

Parameters:
- N_IN, 16, inputs per neuron (fan-in).
- N_OUT, 8, output neurons in the layer.
- N_TIMESTEPS, 4, timesteps per inference.
- RD_LAT, 1, memory read latency in cycles (≥1).
- ADDR_W, 9, memory address width.
- SEL_W, 6, neuron-selector width.
- Elaboration error if any of these fail to fit: N_TIMESTEPS*N_IN, N_OUT*N_IN or N_TIMESTEPS*N_OUT exceeds 2^ADDR_W; N_IN or N_OUT exceeds 2^SEL_W.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin inference (sampled in IDLE only).
- abort  in  1  terminate run, return to IDLE.
- stall  in  1  freeze sequencing.
- busy  out  1  high in INIT..WRITE.
- done  out  1  one-cycle pulse at normal completion.
- cntrl_u_in_select  out  SEL_W  current input index i.
- cntrl_u_out_select  out  SEL_W  current output neuron o.
- cntrl_ac_reset  out  1  accumulator clear.
- cntrl_ac_oen  out  1  accumulate enable (read data valid).
- cntrl_neu_reset  out  1  neuron-state clear.
- cntrl_proc_reset  out  1  spike-processor clear.
- cntrl_in_spk_read_addr  out  ADDR_W  t*N_IN+i.
- cntrl_spkblty_read_addr  out  ADDR_W  o*N_IN+i (weight).
- cntrl_potential_read_addr  out  ADDR_W  o.
- cntrl_beta_read_addr  out  ADDR_W  o.
- cntrl_potential_write_addr  out  ADDR_W  o.
- cntrl_potential_write_we  out  1  potential write strobe.
- cntrl_spk_write_addr  out  ADDR_W  t*N_OUT+o.
- cntrl_spk_write_we  out  1  output-spike write strobe.

Behaviour:
- Reset (reset=0): state IDLE; counters t, o, i = 0; valid delay line cleared; all outputs 0. Takes effect immediately and overrides any run in progress.
- States: IDLE, INIT, CLEAR, ACCUM, DRAIN, FIRE, WRITE, DONE.
- IDLE → INIT when start=1 and abort=0; start is ignored in all other states.
- INIT, 1 cycle: cntrl_neu_reset=1, cntrl_proc_reset=1; t=o=0; → CLEAR.
- CLEAR, 1 cycle: cntrl_ac_reset=1; i=0; → ACCUM.
- ACCUM, N_IN cycles:
  - present in_spk and spkblty addresses for i; cntrl_u_in_select=i; i increments each cycle.
  - i=N_IN-1 → DRAIN.
- cntrl_ac_oen is the ACCUM-issue flag delayed by RD_LAT cycles through the valid delay line. It is high for exactly N_IN cycles, starting RD_LAT cycles after ACCUM entry.
- DRAIN, RD_LAT cycles: no new addresses; delay line empties; → FIRE.
- FIRE, 1 cycle: neuron update using potential/beta at address o. These addresses are held at o from CLEAR through WRITE. → WRITE.
- WRITE, 1 cycle:
  - cntrl_potential_write_we=1 at address o; cntrl_spk_write_we=1 at address t*N_OUT+o.
  - If o<N_OUT-1: o+1, → CLEAR.
  - Else if t<N_TIMESTEPS-1: o=0, t+1, → CLEAR.
  - Else → DONE.
- DONE, 1 cycle: done=1, busy=0; → IDLE.
- cntrl_u_out_select = o throughout INIT..WRITE; 0 in IDLE/DONE.
- Latency with defaults: per neuron N_IN+RD_LAT+3 = 20 cycles. INIT is cycle 0; DONE is cycle 1 + N_TIMESTEPS*N_OUT*20 = 641.
- Stall: state, counters and delay line hold. All strobes (reset, oen, we, done) are forced 0; addresses and selects hold their values.
- Abort (priority over stall): next cycle IDLE; counters cleared; delay line flushed; no done pulse; strobes 0 from that cycle.
- start and abort together in IDLE: remain IDLE.
- Counter wrap: no counter exceeds its bound; the address arithmetic is unsigned, truncated to ADDR_W, and guaranteed to fit by the parameter check.

Decomposition:
- Shared package snn_ctrl_pkg holds:
  - the state encoding (8 states, 3 bits);
  - default widths ADDR_W=9, SEL_W=6;
  - the per-neuron cycle-count function N_IN+RD_LAT+3.
- One sub-module: ctrl_valid_delay, a parametrised RD_LAT-deep shift register with hold (stall) and flush (abort).

Test Plan:
- Defaults, start pulse:
  - busy rises in the cycle after start; done pulses at cycle 641; exactly 32 potential writes and 32 spike writes occur.
  - Spike write addresses run 0..31 in order.
- First neuron, t=0:
  - ac_reset at cycle 1; spkblty addresses 0..15 and in_spk addresses 0..15 in cycles 2..17; ac_oen high in cycles 3..18.
  - FIRE at cycle 19, WRITE at cycle 20 with potential address 0 and spike address 0.
- RD_LAT=3, N_IN=4, N_OUT=2, N_TIMESTEPS=1:
  - ac_oen high for exactly 4 cycles, starting 3 cycles after ACCUM entry; done at cycle 1+2*10 = 21.
- Stall held 5 cycles mid-ACCUM at i=7:
  - addresses hold at 7; ac_oen and we stay 0; on release, sequencing resumes at i=7; done is delayed exactly 5 cycles, to cycle 646.
- Abort in FIRE:
  - next cycle IDLE; no done pulse; no write strobe; a new start re-runs from t=o=0.
- Reset asserted mid-WRITE: outputs go to 0 immediately; after release the block is in IDLE with busy=0; start while busy is ignored.
